spi_txn_sequencer: RTL and testbench
====================================

Name: spi_txn_sequencer

Overview:
Command-driven sequencer sitting directly upstream of the SPI master/3-slave top. Buffers byte-transfer commands (target slave + byte) in a small FIFO. For each command it drives the master's load, one-hot slave-select (s0/s1/s2) and data_in, times the transfer, and captures data_out_master. The captured byte is returned on a valid/ready response port. This replaces hand-sequenced load/select stimulus with a reusable hardware front end.

Parameters:
N, 8, transfer byte width (matches master data_in/data_out_master).
FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2.
LOAD_CYCLES, 3, clocks load is held high per transfer; >=1.
XFER_CYCLES, 20, clocks after load drops before data_out_master is sampled; >=N.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO can accept; = (fifo_count < FIFO_DEPTH).
cmd_slave  in  2  target: 0->s0, 1->s1, 2->s2, 3 invalid.
cmd_data  in  N  byte to transmit.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts response.
rsp_data  out  N  byte received from master (0 on error).
rsp_slave  out  2  cmd_slave echoed.
rsp_err  out  1  1 = invalid slave id, no transfer performed.
load  out  1  to master load.
s0, s1, s2  out  1 each  one-hot slave select to master.
data_in  out  N  to master data_in.
data_out_master  in  N  byte shifted in by master.
busy  out  1  FSM not in IDLE.
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, FSM->IDLE, counters 0. Outputs load, s0-s2, data_in, rsp_valid, rsp_data, rsp_slave, rsp_err, busy and fifo_count all 0. Reset mid-transfer aborts it; no response is produced.
- All outputs are registered. cmd_ready is combinational from fifo_count.
- Push when cmd_valid && cmd_ready. Full FIFO: cmd_ready=0; no bypass, even if a pop occurs the same cycle. Simultaneous push and pop when not full: count unchanged.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, RESP.
- IDLE: if fifo_count>0, pop head in cycle t.
  - Valid slave: ->LOAD. From t+1, load=1, the selected s_i=1 (others 0), data_in=cmd_data.
  - Slave==3: ->RESP directly. rsp_err=1, rsp_data=0, and load/selects never assert.
- LOAD: held exactly LOAD_CYCLES cycles (t+1 .. t+LOAD_CYCLES), then ->SHIFT.
- SHIFT: load=0; select and data_in held; lasts XFER_CYCLES cycles; ->CAPTURE.
- CAPTURE: one cycle. rsp_data<=data_out_master, rsp_slave<=id, rsp_err<=0. Selects deassert with the RESP entry.
- Valid-command latency: rsp_valid first high at t+LOAD_CYCLES+XFER_CYCLES+2.
- RESP: rsp_valid=1. rsp_data, rsp_slave and rsp_err are stable until the rsp_ready handshake. On handshake, rsp_valid falls at the next edge, ->IDLE. Selects and data_in are 0 in IDLE and RESP.
- Back-to-back commands: at least one IDLE cycle between transfers (select gap >=2 cycles). The next pop occurs in the IDLE cycle following the handshake.
- Commands are processed strictly in FIFO order. FIFO read/write pointers wrap modulo FIFO_DEPTH.
- The FIFO keeps accepting pushes while the FSM is stalled in RESP.

Test Plan:
1. Reset, push {slave0, 0x3D}; model returns 0xDB with rsp_ready=1. Expect load high exactly 3 cycles with s0=1 and data_in=0x3D. s1=s2=0 throughout. rsp_valid at pop+25 with rsp_data=0xDB, rsp_slave=0, rsp_err=0.
2. Push {slave1, 0x3D} and {slave2, 0x3D} back to back; model returns 0x4A then 0x1A. Expect s1 window then s2 window, never overlapping, with >=1 IDLE cycle between. Responses arrive in order: 0x4A/1, then 0x1A/2.
3. Hold rsp_ready=0 and push 5 commands. Expect cmd_ready=0 after 4 accepted while the FSM stalls in RESP. The 5th is accepted only after a pop. rsp_data is unchanged during the stall.
4. Push {slave3, 0xFF}. Expect no load/select activity, rsp_err=1, rsp_data=0, rsp_valid within 2 cycles of the pop.
5. Assert rst in SHIFT of a slave0 transfer with 2 queued commands. Next cycle: all outputs 0, fifo_count=0. No response is ever produced for the aborted command.
6. Push when fifo_count=3 in the same cycle as an IDLE pop. Expect count to stay at 3 and the pushed entry to be served after the existing entries (pointer wrap check).

Source files
------------

// File: rtl/spi_txn_sequencer.sv
// ---------------------------------------------------------------------------
// spi_txn_sequencer
//   Command-driven front end for the SPI master / 3-slave top. Byte-transfer
//   commands (target slave + byte) are queued in a small FIFO. For each one
//   the sequencer pulses the master's load, drives the one-hot slave select
//   and data_in, waits out the transfer, captures data_out_master and hands
//   the received byte back on a valid/ready response port.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake (ready = FIFO not full)
//   cmd_slave         : 0..2 -> s0..s2, 3 -> invalid (error response only)
//   cmd_data          : byte to transmit
//   rsp_valid/ready   : response handshake
//   rsp_data          : received byte (0 for an invalid command)
//   rsp_slave/rsp_err : echoed slave id / invalid-id flag
//   load, s0..s2      : master load and one-hot slave select
//   data_in           : byte presented to the master
//   data_out_master   : byte shifted in by the master
//   busy              : sequencer not idle
//   fifo_count        : commands currently queued
// ---------------------------------------------------------------------------
module spi_txn_sequencer #(
   parameter int N           = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int LOAD_CYCLES = 3,
   parameter int XFER_CYCLES = 20
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_slave,
   input  logic [N-1:0]                  cmd_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [N-1:0]                  rsp_data,
   output logic [1:0]                    rsp_slave,
   output logic                          rsp_err,
   output logic                          load,
   output logic                          s0,
   output logic                          s1,
   output logic                          s2,
   output logic [N-1:0]                  data_in,
   input  logic [N-1:0]                  data_out_master,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(LOAD_CYCLES + XFER_CYCLES + 1);

   typedef struct packed {
      logic [1:0]   slave;
      logic [N-1:0] data;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Command FIFO. Depth is a power of two, so the pointers wrap on their
   // own; the count carries the extra bit that tells full from empty.
   // ------------------------------------------------------------------
   cmd_t          fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   cmd_t          head;
   logic          push;
   logic          pop;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   cmd_t          cur;
   cmd_t          cur_n;
   logic          sel_on;

   // Full means no push at all, even when a pop happens this cycle.
   assign cmd_ready = (fifo_count < (AW+1)'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && (fifo_count != '0);
   assign head      = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= '{slave: cmd_slave, data: cmd_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cur   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cur   <= cur_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cur_n   = pop ? head : cur;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (pop)
               state_n = (head.slave == 2'd3) ? RESP : LOAD;
         end
         LOAD: begin
            if (cnt == CW'(LOAD_CYCLES - 1)) begin
               state_n = SHIFT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         SHIFT: begin
            if (cnt == CW'(XFER_CYCLES - 1)) begin
               state_n = CAPTURE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         CAPTURE: state_n = RESP;
         RESP: begin
            // rsp_valid is always high in RESP, so ready alone is the handshake
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Select/data stay up through CAPTURE so the master still drives the
      // captured byte; they drop as RESP is entered.
      sel_on = (state_n == LOAD) || (state_n == SHIFT) || (state_n == CAPTURE);
   end

   // ------------------------------------------------------------------
   // Registered outputs, computed from the next state so they line up
   // with the state they describe.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         load      <= 1'b0;
         s0        <= 1'b0;
         s1        <= 1'b0;
         s2        <= 1'b0;
         data_in   <= '0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_slave <= '0;
         rsp_err   <= 1'b0;
      end else begin
         load      <= (state_n == LOAD);
         s0        <= sel_on && (cur_n.slave == 2'd0);
         s1        <= sel_on && (cur_n.slave == 2'd1);
         s2        <= sel_on && (cur_n.slave == 2'd2);
         data_in   <= sel_on ? cur_n.data : '0;
         busy      <= (state_n != IDLE);
         rsp_valid <= (state_n == RESP);
         if (state == CAPTURE) begin
            rsp_data  <= data_out_master;
            rsp_slave <= cur.slave;
            rsp_err   <= 1'b0;
         end else if (pop && head.slave == 2'd3) begin
            rsp_data  <= '0;
            rsp_slave <= 2'd3;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
module tb_spi_txn_sequencer;
   localparam int N   = 8;
   localparam int FD  = 4;
   localparam int LC  = 3;
   localparam int XC  = 20;
   localparam int LAT = LC + XC + 2;

   typedef struct packed {
      logic [1:0] slave;
      logic [7:0] data;
      logic       err;
   } rsp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_slave;
   logic [7:0] cmd_data;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic [1:0] rsp_slave;
   logic       rsp_err;
   logic       load, s0, s1, s2;
   logic [7:0] data_in, data_out_master;
   logic       busy;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_txn_sequencer #(.N(N), .FIFO_DEPTH(FD), .LOAD_CYCLES(LC), .XFER_CYCLES(XC)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_slave(rsp_slave),
      .rsp_err(rsp_err), .load(load), .s0(s0), .s1(s1), .s2(s2), .data_in(data_in),
      .data_out_master(data_out_master), .busy(busy), .fifo_count(fifo_count)
   );

   // Slave-side model: each slave answers with the transmitted byte XOR a
   // per-slave key (0x3D -> 0xDB / 0x4A / 0x1A for slaves 0 / 1 / 2).
   function automatic logic [7:0] key_of(input logic [1:0] s);
      case (s)
         2'd0:    return 8'hE6;
         2'd1:    return 8'h77;
         2'd2:    return 8'h27;
         default: return 8'h00;
      endcase
   endfunction

   assign data_out_master = s0 ? (data_in ^ key_of(2'd0)) :
                            s1 ? (data_in ^ key_of(2'd1)) :
                            s2 ? (data_in ^ key_of(2'd2)) : 8'h00;

   function automatic rsp_t model(input logic [1:0] s, input logic [7:0] d);
      rsp_t r;
      r.slave = s;
      r.err   = (s == 2'd3);
      r.data  = r.err ? 8'h00 : (d ^ key_of(s));
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Observation: cycle stamps and protocol statistics gathered at negedge
   // ------------------------------------------------------------------
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   pop_q[$], load_rise_q[$], load_len_q[$], load_slv_q[$], rsp_rise_q[$];
   logic [7:0] load_dat_q[$];
   rsp_t act_q[$], exp_q[$];
   int   onehot_err, hold_err, stall_err, sel_win, min_gap, last_end;
   int   load_len, w_idx;
   logic [7:0] w_dat;
   logic p_load = 0, p_sel = 0, p_vld = 0, p_rdy = 0, p_e = 0;
   logic [7:0] p_d = 0;
   logic [1:0] p_s = 0;
   bit   done;

   initial forever begin
      int   nsel, sidx;
      rsp_t r;
      @(negedge clk);
      nsel = int'(s0) + int'(s1) + int'(s2);
      sidx = s0 ? 0 : s1 ? 1 : s2 ? 2 : -1;
      if (rst) begin
         p_load = 0; p_sel = 0; p_vld = 0; p_rdy = 0; last_end = -1;
      end else begin
         if (!busy && fifo_count != 0) pop_q.push_back(cyc);
         if (nsel > 1 || (load && nsel == 0)) onehot_err++;
         if (load && !p_load) begin
            load_rise_q.push_back(cyc); load_slv_q.push_back(sidx);
            load_dat_q.push_back(data_in); load_len = 0;
         end
         if (load) load_len++;
         if (!load && p_load) load_len_q.push_back(load_len);
         if (nsel != 0 && !p_sel) begin
            sel_win++;
            if (last_end >= 0 && (cyc - last_end - 1) < min_gap) min_gap = cyc - last_end - 1;
            w_idx = sidx; w_dat = data_in;
         end else if (nsel != 0 && (sidx != w_idx || data_in !== w_dat)) hold_err++;
         if (nsel != 0) last_end = cyc;
         if (nsel == 0 && data_in !== 8'h00) hold_err++;
         if (rsp_valid && !p_vld) rsp_rise_q.push_back(cyc);
         if (p_vld && !p_rdy && (!rsp_valid || rsp_data !== p_d || rsp_slave !== p_s || rsp_err !== p_e))
            stall_err++;
         if (rsp_valid && rsp_ready) begin
            r.slave = rsp_slave; r.data = rsp_data; r.err = rsp_err;
            act_q.push_back(r);
         end
         p_load = load; p_sel = (nsel != 0); p_vld = rsp_valid; p_rdy = rsp_ready;
         p_d = rsp_data; p_s = rsp_slave; p_e = rsp_err;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change 2 time units after the rising edge)
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic clear();
      pop_q.delete(); load_rise_q.delete(); load_len_q.delete(); load_slv_q.delete();
      load_dat_q.delete(); rsp_rise_q.delete(); act_q.delete(); exp_q.delete();
      onehot_err = 0; hold_err = 0; stall_err = 0; sel_win = 0; min_gap = 1000; last_end = -1;
   endtask

   task automatic push(input logic [1:0] s, input logic [7:0] d);
      bit acc = 0;
      cmd_valid = 1'b1; cmd_slave = s; cmd_data = d;
      for (int k = 0; k < 400 && !acc; k++) begin
         @(negedge clk); acc = cmd_ready;
         step();
      end
      cmd_valid = 1'b0;
      if (acc) exp_q.push_back(model(s, d));
      else begin
         errors++;
         $display("FAIL push_timeout: cmd_ready never high for slave %0d data %h", s, d);
      end
   endtask

   task automatic wait_rsp(input int n, output bit ok);
      for (int k = 0; k < 1500 && act_q.size() < n; k++) step();
      ok = (act_q.size() >= n);
   endtask

   task automatic wait_valid(output bit ok);
      for (int k = 0; k < 100 && !rsp_valid; k++) step();
      ok = rsp_valid;
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; cmd_valid = 0; cmd_slave = 0; cmd_data = 0; rsp_ready = 0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({load, s0, s1, s2, data_in, busy} !== 12'h0) begin
         errors++; $display("FAIL reset_xfer_outs: got %b required 0", {load, s0, s1, s2, data_in, busy});
      end
      checks++;
      if ({rsp_valid, rsp_data, rsp_slave, rsp_err} !== 12'h0) begin
         errors++; $display("FAIL reset_rsp_outs: got %h required 0", {rsp_valid, rsp_data, rsp_slave, rsp_err});
      end
      checks++;
      if (fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_fifo: count %0d ready %b required 0/1", fifo_count, cmd_ready);
      end
      step();
   endtask

   task automatic test_single();
      bit ok;
      clear(); rsp_ready = 1'b1;
      push(2'd0, 8'h3D);
      wait_rsp(1, ok);
      checks++;
      if (!ok || act_q[0] !== rsp_t'({2'd0, 8'hDB, 1'b0})) begin
         errors++; $display("FAIL single_rsp: got %h required %h (ok=%0d)", ok ? act_q[0] : rsp_t'(0), rsp_t'({2'd0, 8'hDB, 1'b0}), ok);
      end
      checks++;
      if (load_len_q.size() != 1 || load_len_q[0] != LC || load_slv_q[0] != 0 || load_dat_q[0] !== 8'h3D) begin
         errors++; $display("FAIL single_load: pulses %0d len %0d slave %0d data %h required 1/%0d/0/3d",
                            load_len_q.size(), load_len_q.size() ? load_len_q[0] : -1,
                            load_slv_q.size() ? load_slv_q[0] : -1, load_dat_q.size() ? load_dat_q[0] : 8'hxx, LC);
      end
      checks++;
      if (pop_q.size() != 1 || load_rise_q.size() != 1 || rsp_rise_q.size() != 1 ||
          load_rise_q[0] - pop_q[0] != 1 || rsp_rise_q[0] - pop_q[0] != LAT) begin
         errors++; $display("FAIL single_latency: pops %0d load_rise-pop %0d rsp_rise-pop %0d required 1/%0d",
                            pop_q.size(), (pop_q.size() && load_rise_q.size()) ? load_rise_q[0] - pop_q[0] : -1,
                            (pop_q.size() && rsp_rise_q.size()) ? rsp_rise_q[0] - pop_q[0] : -1, LAT);
      end
      checks++;
      if (onehot_err != 0 || hold_err != 0 || sel_win != 1) begin
         errors++; $display("FAIL single_select: onehot_err %0d hold_err %0d windows %0d required 0/0/1", onehot_err, hold_err, sel_win);
      end
      step();
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear(); rsp_ready = 1'b1;
      push(2'd1, 8'h3D);
      push(2'd2, 8'h3D);
      wait_rsp(2, ok);
      checks++;
      if (!ok || act_q[0] !== rsp_t'({2'd1, 8'h4A, 1'b0}) || act_q[1] !== rsp_t'({2'd2, 8'h1A, 1'b0})) begin
         errors++; $display("FAIL b2b_order: got %0d responses first %h second %h required 0x4a/1 then 0x1a/2",
                            act_q.size(), act_q.size() > 0 ? act_q[0] : rsp_t'(0), act_q.size() > 1 ? act_q[1] : rsp_t'(0));
      end
      checks++;
      if (sel_win != 2 || load_slv_q.size() != 2 || load_slv_q[0] != 1 || load_slv_q[1] != 2 || min_gap < 2 || onehot_err != 0) begin
         errors++; $display("FAIL b2b_windows: windows %0d min_gap %0d onehot_err %0d required 2/>=2/0", sel_win, min_gap, onehot_err);
      end
      step();
   endtask

   task automatic test_full_stall();
      bit   ok;
      rsp_t first;
      clear(); rsp_ready = 1'b0;
      first = model(2'd2, 8'h5C);
      push(2'd2, 8'h5C);
      wait_valid(ok);
      for (int i = 0; i < FD; i++) push(2'($urandom_range(0, 2)), 8'($urandom));
      @(negedge clk);
      checks++;
      if (!ok || fifo_count !== 3'(FD) || cmd_ready !== 1'b0) begin
         errors++; $display("FAIL stall_full: count %0d ready %b required %0d/0", fifo_count, cmd_ready, FD);
      end
      step();
      cmd_valid = 1'b1; cmd_slave = 2'd0; cmd_data = 8'hA5;
      repeat (4) step();
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'(FD) || act_q.size() != 0 || rsp_data !== first.data || stall_err != 0) begin
         errors++; $display("FAIL stall_hold: count %0d rsps %0d rsp_data %h stall_err %0d required %0d/0/%h/0",
                            fifo_count, act_q.size(), rsp_data, stall_err, FD, first.data);
      end
      step();
      rsp_ready = 1'b1;
      push(2'd0, 8'hA5);
      wait_rsp(FD + 2, ok);
      checks++;
      if (!ok || act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL stall_count: got %0d responses required %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (act_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL stall_order[%0d]: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
      step();
   endtask

   task automatic test_invalid();
      bit ok;
      clear(); rsp_ready = 1'b1;
      push(2'd3, 8'hFF);
      wait_rsp(1, ok);
      checks++;
      if (!ok || act_q[0] !== rsp_t'({2'd3, 8'h00, 1'b1})) begin
         errors++; $display("FAIL invalid_rsp: got %h required %h", ok ? act_q[0] : rsp_t'(0), rsp_t'({2'd3, 8'h00, 1'b1}));
      end
      checks++;
      if (load_rise_q.size() != 0 || sel_win != 0 || pop_q.size() != 1 || rsp_rise_q.size() != 1 ||
          rsp_rise_q[0] - pop_q[0] < 1 || rsp_rise_q[0] - pop_q[0] > 2) begin
         errors++; $display("FAIL invalid_timing: loads %0d windows %0d pops %0d rsp_rise-pop %0d required 0/0/1/1..2",
                            load_rise_q.size(), sel_win, pop_q.size(),
                            (pop_q.size() && rsp_rise_q.size()) ? rsp_rise_q[0] - pop_q[0] : -1);
      end
      step();
   endtask

   task automatic test_reset_mid();
      clear(); rsp_ready = 1'b1;
      push(2'd0, 8'h11);
      push(2'd1, 8'h22);
      push(2'd2, 8'h33);
      repeat (6) step();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || load !== 1'b0 || s0 !== 1'b1 || fifo_count !== 3'd2) begin
         errors++; $display("FAIL midrst_setup: busy %b load %b s0 %b count %0d required 1/0/1/2", busy, load, s0, fifo_count);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({load, s0, s1, s2, data_in, busy, rsp_valid, rsp_data, rsp_slave, rsp_err, fifo_count} !== 27'h0) begin
         errors++; $display("FAIL midrst_outs: got %h required 0",
                            {load, s0, s1, s2, data_in, busy, rsp_valid, rsp_data, rsp_slave, rsp_err, fifo_count});
      end
      exp_q.delete();
      repeat (LAT + 20) step();
      checks++;
      if (act_q.size() != 0 || rsp_rise_q.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_norsp: rsps %0d rises %0d busy %b required 0/0/0", act_q.size(), rsp_rise_q.size(), busy);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      clear(); rsp_ready = 1'b0;
      push(2'd1, 8'($urandom));
      wait_valid(ok);
      for (int i = 0; i < 3; i++) push(2'($urandom_range(0, 3)), 8'($urandom));
      @(negedge clk);
      checks++;
      if (!ok || fifo_count !== 3'd3) begin
         errors++; $display("FAIL wrap_setup: count %0d valid %b required 3/1", fifo_count, ok);
      end
      step();
      rsp_ready = 1'b1;            // handshake this cycle
      step();
      rsp_ready = 1'b0;            // IDLE pop cycle: push at the same time
      cmd_valid = 1'b1; cmd_slave = 2'd2; cmd_data = 8'hC3;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd3) begin
         errors++; $display("FAIL wrap_popcycle: ready %b busy %b count %0d required 1/0/3", cmd_ready, busy, fifo_count);
      end
      exp_q.push_back(model(2'd2, 8'hC3));
      step();
      cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd3) begin
         errors++; $display("FAIL wrap_count: got %0d required 3", fifo_count);
      end
      step();
      rsp_ready = 1'b1;
      wait_rsp(5, ok);
      checks++;
      if (!ok || act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL wrap_rsps: got %0d required %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (act_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL wrap_order[%0d]: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
      step();
   endtask

   task automatic test_random();
      bit ok;
      clear(); done = 0;
      fork
         begin
            while (!done) begin
               rsp_ready = ($urandom_range(0, 3) != 0);
               step();
            end
         end
      join_none
      for (int i = 0; i < 20; i++) begin
         push(2'($urandom_range(0, 3)), 8'($urandom));
         repeat ($urandom_range(0, 3)) step();
      end
      wait_rsp(20, ok);
      done = 1;
      step(); step();
      rsp_ready = 1'b1;
      checks++;
      if (!ok || act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_count: got %0d responses required %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (act_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand_order[%0d]: got %h required %h", i, act_q[i], exp_q[i]);
         end
      end
      checks++;
      if (onehot_err != 0 || hold_err != 0 || stall_err != 0 || min_gap < 2) begin
         errors++; $display("FAIL rand_protocol: onehot %0d hold %0d stall %0d min_gap %0d required 0/0/0/>=2",
                            onehot_err, hold_err, stall_err, min_gap);
      end
      for (int i = 0; i < load_len_q.size(); i++) begin
         checks++;
         if (load_len_q[i] != LC) begin
            errors++; $display("FAIL rand_load_len[%0d]: got %0d required %0d", i, load_len_q[i], LC);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full_stall();
      test_invalid();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1);
   end
endmodule
